// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared encodings, counter widths and helpers for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;
    localparam int PERF_W   = 16;

    // Saturating increment for the performance counters
    function automatic logic [PERF_W-1:0] sat_inc_perf(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_lat_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_lat_timer
// Purpose  : Read-latency down-counter. Loads RD_LAT on start, decrements
//            every cycle and pulses done in the cycle whose decrement takes
//            the count to zero (i.e. RD_LAT cycles after the start cycle).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_lat_timer
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    logic [LAT_W-1:0] count_q;
    logic [LAT_W-1:0] count_d;

    // Next count: load on start, otherwise count down to zero and stop
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = LAT_W'(RD_LAT);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (fetch / data) arbiter for a single-port memory
//            with fixed read latency. Data has priority; a starvation
//            counter forces a fetch grant after STARVE_MAX data grants.
//            Optional performance counters under MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,output logic [PERF_W-1:0] perf_if_gnt,
    output logic [PERF_W-1:0] perf_d_gnt,
    output logic [PERF_W-1:0] perf_stall,
    output logic [3:0]        perf_starve
`endif
);

    arb_state_e            state_q,     state_d;
    owner_e                owner_q,     owner_d;
    logic [ADDR_W-1:0]     addr_q,      addr_d;
    logic [STARVE_W-1:0]   starve_q,    starve_d;
    logic [DATA_W-1:0]     if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q,   d_rdata_d;

    logic                  lat_start;
    logic                  lat_done;
    logic                  force_if;

    mem_arb_lat_timer #(
        .RD_LAT (RD_LAT)
    ) u_lat_timer (
        .clk   (clk),
        .rst   (rst),
        .start (lat_start),
        .done  (lat_done)
    );

    // Grant selection, memory drive, read completion and next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_addr   = '0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        lat_start  = 1'b0;
        force_if   = 1'b0;

        case (state_q)
            IDLE: begin
                force_if = if_req && d_req && (starve_q == STARVE_W'(STARVE_MAX));
                if (d_req && !force_if) begin
                    d_gnt    = 1'b1;
                    mem_addr = d_addr;
                    if (d_we) begin
                        mem_wr    = 1'b1;
                        mem_wdata = d_wdata;
                    end else begin
                        lat_start = 1'b1;
                        state_d   = RD_WAIT;
                        owner_d   = OWN_D;
                        addr_d    = d_addr;
                    end
                    if (if_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (if_req) begin
                    if_gnt    = 1'b1;
                    mem_addr  = if_addr;
                    lat_start = 1'b1;
                    state_d   = RD_WAIT;
                    owner_d   = OWN_IF;
                    addr_d    = if_addr;
                    starve_d  = '0;
                end
                // Fetch not waiting: nothing to protect
                if (!if_req) begin
                    starve_d = '0;
                end
            end
            RD_WAIT: begin
                mem_addr = addr_q;
                if (lat_done) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rvalid  = 1'b1;
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is presented in the completion cycle and held afterwards
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

    // Core state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_if_gnt_q, perf_if_gnt_d;
    logic [PERF_W-1:0] perf_d_gnt_q,  perf_d_gnt_d;
    logic [PERF_W-1:0] perf_stall_q,  perf_stall_d;
    logic [3:0]        perf_starve_q, perf_starve_d;

    // Saturating event counters: grants, stalled cycles, forced fetch grants
    always_comb begin
        perf_if_gnt_d = perf_if_gnt_q;
        perf_d_gnt_d  = perf_d_gnt_q;
        perf_stall_d  = perf_stall_q;
        perf_starve_d = perf_starve_q;
        if (if_gnt) begin
            perf_if_gnt_d = sat_inc_perf(perf_if_gnt_q);
        end
        if (d_gnt) begin
            perf_d_gnt_d = sat_inc_perf(perf_d_gnt_q);
        end
        if ((if_req || d_req) && !if_gnt && !d_gnt) begin
            perf_stall_d = sat_inc_perf(perf_stall_q);
        end
        if (force_if && if_gnt && (perf_starve_q != 4'hF)) begin
            perf_starve_d = perf_starve_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_gnt_q <= '0;
            perf_d_gnt_q  <= '0;
            perf_stall_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_if_gnt_q <= perf_if_gnt_d;
            perf_d_gnt_q  <= perf_d_gnt_d;
            perf_stall_q  <= perf_stall_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_if_gnt = perf_if_gnt_q;
    assign perf_d_gnt  = perf_d_gnt_q;
    assign perf_stall  = perf_stall_q;
    assign perf_starve = perf_starve_q;
`endif

endmodule
`default_nettype wire
